// File: rtl/approx_mult_pipe_if.sv
// Handshake bundle for the pipelined approximate multiplier.
// The slave side is the multiplier itself; the master side is whoever feeds it
// operands and consumes its products.
interface approx_mult_pipe_if #(
   parameter int W     = 8,
   parameter int CNT_W = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [W-1:0]         in_x;
   logic [W-1:0]         in_y;
   logic                 in_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*W-1:0]       out_z;
   logic                 out_mode;
   logic [CNT_W-1:0]     approx_cnt;

   modport master (
      output in_valid,
      output in_x,
      output in_y,
      output in_mode,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_z,
      input  out_mode,
      input  approx_cnt
   );

   modport slave (
      input  in_valid,
      input  in_x,
      input  in_y,
      input  in_mode,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_z,
      output out_mode,
      output approx_cnt
   );
endinterface

// File: rtl/approx_mult_pipe.sv
// Three-stage pipelined W x W unsigned multiplier with a per-transaction choice
// between the exact product and an approximate one. In approximate mode the low
// L rows of the partial-product array are OR-compressed in pairs and every
// column below TRUNC coming from those rows is dropped; the upper rows are
// summed exactly. A single advance signal stalls the whole pipe (no bubble
// collapsing), and a saturating counter tracks approximate results delivered.
module approx_mult_pipe #(
   parameter int W     = 8,
   parameter int L     = 6,
   parameter int TRUNC = W - 1,
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               rst,
   approx_mult_pipe_if.slave bus
);

   localparam logic [2*W-1:0]   KEEP_MASK = {(2*W){1'b1}} << TRUNC;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic             adv;

   logic             v1;
   logic [W-1:0]     x1;
   logic [W-1:0]     y1;
   logic             m1;

   logic             v2;
   logic [2*W-1:0]   e2;
   logic [2*W-1:0]   a2;
   logic             m2;

   logic             v3;
   logic [2*W-1:0]   z3;
   logic             m3;

   logic [CNT_W-1:0] cnt;

   logic [2*W-1:0]   y_ext;
   logic [2*W-1:0]   e_comb;
   logic [2*W-1:0]   a_comb;
   logic [2*W-1:0]   exact_comb;
   logic [2*W-1:0]   pair_lo;
   logic [2*W-1:0]   pair_hi;
   logic [W-1:0]     x_sh;

   // The pipe moves whenever the output slot is empty or being drained.
   assign adv            = !v3 || bus.out_ready;
   assign bus.in_ready   = adv;
   assign bus.out_valid  = v3;
   assign bus.out_z      = z3;
   assign bus.out_mode   = m3;
   assign bus.approx_cnt = cnt;

   assign y_ext = {{W{1'b0}}, y1};

   // Build the exact upper-row sum E, the OR-compressed low-row sum A, and the
   // full exact product from the operands held in stage 1.
   always_comb begin
      e_comb     = '0;
      a_comb     = '0;
      pair_lo    = '0;
      pair_hi    = '0;
      x_sh       = '0;
      exact_comb = {{W{1'b0}}, x1} * y_ext;
      for (int i = L; i < W; i++) begin
         x_sh = x1 >> i;
         if (x_sh[0]) begin
            e_comb = e_comb + (y_ext << i);
         end
      end
      for (int k = 0; k < L / 2; k++) begin
         x_sh    = x1 >> (2 * k);
         pair_lo = x_sh[0] ? (y_ext << (2 * k)) : '0;
         pair_hi = x_sh[1] ? (y_ext << (2 * k + 1)) : '0;
         a_comb  = a_comb + ((pair_lo | pair_hi) & KEEP_MASK);
      end
   end

   // Stage 1: capture the operands and mode tag alongside the input valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         x1 <= '0;
         y1 <= '0;
         m1 <= 1'b0;
      end else if (adv) begin
         v1 <= bus.in_valid;
         x1 <= bus.in_x;
         y1 <= bus.in_y;
         m1 <= bus.in_mode;
      end
   end

   // Stage 2: hold E and A for approximate transactions, or the exact product
   // (with A forced to zero) so stage 3 can use one adder for both modes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2 <= 1'b0;
         e2 <= '0;
         a2 <= '0;
         m2 <= 1'b0;
      end else if (adv) begin
         v2 <= v1;
         m2 <= m1;
         if (m1) begin
            e2 <= e_comb;
            a2 <= a_comb;
         end else begin
            e2 <= exact_comb;
            a2 <= '0;
         end
      end
   end

   // Stage 3: final sum; this register drives the result bus directly so it
   // stays frozen while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3 <= 1'b0;
         z3 <= '0;
         m3 <= 1'b0;
      end else if (adv) begin
         v3 <= v2;
         z3 <= e2 + a2;
         m3 <= m2;
      end
   end

   // Count approximate results actually handed off, sticking at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (v3 && bus.out_ready && m3 && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe. Three instances share one stimulus
// stream: the default configuration, a 2-bit counter variant, and an L=0
// variant whose approximate mode must equal the exact product.
module tb_approx_mult_pipe;

   localparam int W     = 8;
   localparam int L     = 6;
   localparam int TRUNC = 7;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in_x;
   logic [W-1:0] in_y;
   logic         in_mode;
   logic         out_ready;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   int exp_cnt2 = 0;

   logic [2*W-1:0] qz[$];
   logic           qm[$];
   logic [2*W-1:0] ql0[$];

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   approx_mult_pipe_if #(.W(W), .CNT_W(16)) if0 ();
   approx_mult_pipe_if #(.W(W), .CNT_W(2))  if1 ();
   approx_mult_pipe_if #(.W(W), .CNT_W(16)) if2 ();

   assign if0.in_valid  = in_valid;
   assign if0.in_x      = in_x;
   assign if0.in_y      = in_y;
   assign if0.in_mode   = in_mode;
   assign if0.out_ready = out_ready;
   assign if1.in_valid  = in_valid;
   assign if1.in_x      = in_x;
   assign if1.in_y      = in_y;
   assign if1.in_mode   = in_mode;
   assign if1.out_ready = out_ready;
   assign if2.in_valid  = in_valid;
   assign if2.in_x      = in_x;
   assign if2.in_y      = in_y;
   assign if2.in_mode   = in_mode;
   assign if2.out_ready = out_ready;

   approx_mult_pipe #(.W(W), .L(L), .TRUNC(TRUNC), .CNT_W(16)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (if0.slave)
   );

   approx_mult_pipe #(.W(W), .L(L), .TRUNC(TRUNC), .CNT_W(2)) u_cnt2 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   approx_mult_pipe #(.W(W), .L(0), .TRUNC(TRUNC), .CNT_W(16)) u_l0 (
      .clk (clk),
      .rst (rst),
      .bus (if2.slave)
   );

   // Reference product: exact rows times weights for rows >= l, then each
   // low row pair ORed as whole integers and floored to a multiple of 2^trunc.
   function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic mode, input int l, input int trunc);
      longint sum;
      longint r0;
      longint r1;
      longint unit;
      if (!mode) return (2*W)'(longint'(x) * longint'(y));
      sum  = 0;
      unit = longint'(1) << trunc;
      for (int i = l; i < W; i++) begin
         sum += longint'((x >> i) & 1) * longint'(y) * (longint'(1) << i);
      end
      for (int k = 0; k < l / 2; k++) begin
         r0 = longint'((x >> (2 * k)) & 1) * longint'(y) * (longint'(1) << (2 * k));
         r1 = longint'((x >> (2 * k + 1)) & 1) * longint'(y) * (longint'(1) << (2 * k + 1));
         sum += ((r0 | r1) / unit) * unit;
      end
      return (2*W)'(sum);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      in_mode   = 1'b0;
      out_ready = 1'b1;
      #12;
      checks++;
      if (if0.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0d want 0", if0.out_valid); end
      checks++;
      if (if0.out_z !== '0) begin errors++; $display("[TB] FAIL reset_out_z got %0d want 0", if0.out_z); end
      checks++;
      if (if0.out_mode !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_mode got %0d want 0", if0.out_mode); end
      checks++;
      if (if0.approx_cnt !== '0) begin errors++; $display("[TB] FAIL reset_approx_cnt got %0d want 0", if0.approx_cnt); end
      checks++;
      if (if0.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0d want 1", if0.in_ready); end
      @(negedge clk);
      rst = 1'b0;
      exp_cnt  = 0;
      exp_cnt2 = 0;
      tick();
   endtask

   task automatic test_directed();
      logic [W-1:0]   dx[4];
      logic [W-1:0]   dy[4];
      logic           dm[4];
      logic [2*W-1:0] dz[4];
      dx = '{8'd200, 8'd255, 8'd3, 8'h40};
      dy = '{8'd123, 8'd255, 8'd255, 8'd3};
      dm = '{1'b0, 1'b1, 1'b1, 1'b1};
      dz = '{16'd24600, 16'd59328, 16'd384, 16'd192};
      out_ready = 1'b1;
      for (int v = 0; v < 4; v++) begin
         in_valid = 1'b1;
         in_x     = dx[v];
         in_y     = dy[v];
         in_mode  = dm[v];
         checks++;
         if (if0.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL dir_in_ready v%0d got %0d want 1", v, if0.in_ready); end
         tick();
         in_valid = 1'b0;
         for (int c = 1; c < 3; c++) begin
            checks++;
            if (if0.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL dir_early_valid v%0d cycle t+%0d got %0d want 0", v, c, if0.out_valid); end
            tick();
         end
         checks++;
         if (if0.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL dir_latency v%0d out_valid got %0d want 1", v, if0.out_valid); end
         checks++;
         if (if0.out_z !== dz[v]) begin errors++; $display("[TB] FAIL dir_out_z v%0d got %0d want %0d", v, if0.out_z, dz[v]); end
         checks++;
         if (if0.out_mode !== dm[v]) begin errors++; $display("[TB] FAIL dir_out_mode v%0d got %0d want %0d", v, if0.out_mode, dm[v]); end
         tick();
         if (dm[v]) begin exp_cnt++; exp_cnt2++; end
         checks++;
         if (if0.approx_cnt !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL dir_approx_cnt v%0d got %0d want %0d", v, if0.approx_cnt, exp_cnt); end
      end
   endtask

   task automatic test_back_to_back();
      int sent  = 0;
      int got   = 0;
      int first = -1;
      int last  = -1;
      int cyc   = 0;
      logic acc;
      out_ready = 1'b1;
      while (got < 10 && cyc < 40) begin
         if (sent < 10) begin
            in_valid = 1'b1;
            in_x     = 8'($urandom);
            in_y     = 8'($urandom);
            in_mode  = 1'($urandom);
            checks++;
            if (if0.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready cycle %0d got %0d want 1", cyc, if0.in_ready); end
         end else begin
            in_valid = 1'b0;
         end
         if (if0.out_valid === 1'b1) begin
            checks++;
            if (qz.size() == 0) begin
               errors++; $display("[TB] FAIL b2b_unexpected_output got %0d want none", if0.out_z);
            end else begin
               if (if0.out_z !== qz[0] || if0.out_mode !== qm[0]) begin
                  errors++; $display("[TB] FAIL b2b_result #%0d got z=%0d m=%0d want z=%0d m=%0d", got, if0.out_z, if0.out_mode, qz[0], qm[0]);
               end
               checks++;
               if (if2.out_z !== ql0[0]) begin errors++; $display("[TB] FAIL b2b_l0_result #%0d got %0d want %0d", got, if2.out_z, ql0[0]); end
               if (qm[0]) begin exp_cnt++; exp_cnt2++; end
               void'(qz.pop_front());
               void'(qm.pop_front());
               void'(ql0.pop_front());
            end
            got++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         acc = in_valid && if0.in_ready;
         if (acc) begin
            qz.push_back(model(in_x, in_y, in_mode, L, TRUNC));
            qm.push_back(in_mode);
            ql0.push_back(model(in_x, in_y, in_mode, 0, TRUNC));
            sent++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (got != 10) begin errors++; $display("[TB] FAIL b2b_count got %0d want 10", got); end
      checks++;
      if (last - first != 9) begin errors++; $display("[TB] FAIL b2b_throughput span got %0d want 9", last - first); end
      checks++;
      if (if0.approx_cnt !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL b2b_approx_cnt got %0d want %0d", if0.approx_cnt, exp_cnt); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0]   tx[4];
      logic [W-1:0]   ty[4];
      logic           tm[4];
      logic [2*W-1:0] first_z;
      int n         = 0;
      int delivered = 0;
      int first_cyc = -1;
      int cyc       = 0;
      for (int i = 0; i < 4; i++) begin
         tx[i] = 8'($urandom);
         ty[i] = 8'($urandom);
         tm[i] = 1'(i % 2);
      end
      first_z   = '0;
      out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         in_valid = (n < 4);
         if (n < 4) begin in_x = tx[n]; in_y = ty[n]; in_mode = tm[n]; end
         if (if0.out_valid === 1'b1) begin
            if (first_cyc < 0) begin
               first_cyc = c;
               first_z   = if0.out_z;
            end else begin
               checks++;
               if (if0.out_z !== first_z) begin errors++; $display("[TB] FAIL bp_stable cycle %0d got %0d want %0d", c, if0.out_z, first_z); end
            end
            checks++;
            if (if0.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready cycle %0d got %0d want 0", c, if0.in_ready); end
         end
         if (in_valid && if0.in_ready) begin
            qz.push_back(model(in_x, in_y, in_mode, L, TRUNC));
            qm.push_back(in_mode);
            n++;
         end
         tick();
      end
      checks++;
      if (n != 3) begin errors++; $display("[TB] FAIL bp_accepted got %0d want 3", n); end
      checks++;
      if (first_cyc != 3) begin errors++; $display("[TB] FAIL bp_first_latency got %0d want 3", first_cyc); end
      checks++;
      if (qz.size() == 0 || first_z !== qz[0]) begin errors++; $display("[TB] FAIL bp_first_value got %0d want %0d", first_z, qz.size() ? qz[0] : 16'd0); end
      out_ready = 1'b1;
      while (delivered < 4 && cyc < 20) begin
         in_valid = (n < 4);
         if (n < 4) begin in_x = tx[n]; in_y = ty[n]; in_mode = tm[n]; end
         if (if0.out_valid === 1'b1) begin
            checks++;
            if (qz.size() == 0) begin
               errors++; $display("[TB] FAIL bp_unexpected_output got %0d want none", if0.out_z);
            end else begin
               if (if0.out_z !== qz[0] || if0.out_mode !== qm[0]) begin
                  errors++; $display("[TB] FAIL bp_order #%0d got z=%0d m=%0d want z=%0d m=%0d", delivered, if0.out_z, if0.out_mode, qz[0], qm[0]);
               end
               if (qm[0]) begin exp_cnt++; exp_cnt2++; end
               void'(qz.pop_front());
               void'(qm.pop_front());
            end
            delivered++;
         end
         if (in_valid && if0.in_ready) begin
            qz.push_back(model(in_x, in_y, in_mode, L, TRUNC));
            qm.push_back(in_mode);
            n++;
         end
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (delivered != 4) begin errors++; $display("[TB] FAIL bp_delivered got %0d want 4", delivered); end
      checks++;
      if (n != 4) begin errors++; $display("[TB] FAIL bp_fourth_accepted got %0d want 4", n); end
      checks++;
      if (if0.approx_cnt !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL bp_approx_cnt got %0d want %0d", if0.approx_cnt, exp_cnt); end
   endtask

   task automatic test_reset_midflight();
      logic stale = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_mode   = 1'b1;
      in_x      = 8'd255;
      in_y      = 8'd255;
      tick();
      in_x = 8'd3;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      checks++;
      if (if0.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_valid got %0d want 1", if0.out_valid); end
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (if0.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_valid got %0d want 0", if0.out_valid); end
      checks++;
      if (if0.out_z !== '0) begin errors++; $display("[TB] FAIL mid_out_z got %0d want 0", if0.out_z); end
      checks++;
      if (if0.approx_cnt !== '0) begin errors++; $display("[TB] FAIL mid_approx_cnt got %0d want 0", if0.approx_cnt); end
      checks++;
      if (if1.approx_cnt !== '0) begin errors++; $display("[TB] FAIL mid_cnt2 got %0d want 0", if1.approx_cnt); end
      #2;
      rst = 1'b0;
      exp_cnt  = 0;
      exp_cnt2 = 0;
      qz.delete();
      qm.delete();
      ql0.delete();
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (if0.out_valid !== 1'b0 || if2.out_valid !== 1'b0) stale = 1'b1;
         tick();
      end
      checks++;
      if (stale !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale got %0d want 0", stale); end
   endtask

   task automatic test_saturation();
      int sent   = 0;
      int handed = 0;
      int cyc    = 0;
      logic handoff;
      logic [1:0] want2;
      out_ready = 1'b1;
      while (handed < 5 && cyc < 30) begin
         in_valid = (sent < 5);
         in_mode  = 1'b1;
         in_x     = 8'($urandom);
         in_y     = 8'($urandom);
         handoff  = (if0.out_valid === 1'b1);
         if (handoff) begin
            checks++;
            if (qz.size() == 0) begin
               errors++; $display("[TB] FAIL sat_unexpected_output got %0d want none", if0.out_z);
            end else begin
               if (if0.out_z !== qz[0]) begin errors++; $display("[TB] FAIL sat_result #%0d got %0d want %0d", handed, if0.out_z, qz[0]); end
               void'(qz.pop_front());
               void'(qm.pop_front());
            end
         end
         if (in_valid && if0.in_ready) begin
            qz.push_back(model(in_x, in_y, 1'b1, L, TRUNC));
            qm.push_back(1'b1);
            sent++;
         end
         tick();
         cyc++;
         if (handoff) begin
            handed++;
            exp_cnt++;
            exp_cnt2 = (exp_cnt2 < 3) ? exp_cnt2 + 1 : 3;
            want2 = 2'(exp_cnt2);
            checks++;
            if (if1.approx_cnt !== want2) begin errors++; $display("[TB] FAIL sat_cnt2 hand-off %0d got %0d want %0d", handed, if1.approx_cnt, want2); end
            checks++;
            if (if0.approx_cnt !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL sat_cnt16 hand-off %0d got %0d want %0d", handed, if0.approx_cnt, exp_cnt); end
         end
      end
      in_valid = 1'b0;
      checks++;
      if (handed != 5) begin errors++; $display("[TB] FAIL sat_handed got %0d want 5", handed); end
   endtask

   task automatic test_l0();
      int cyc = 0;
      logic [2*W-1:0] want_main;
      want_main = model(8'd17, 8'd9, 1'b1, L, TRUNC);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_mode   = 1'b1;
      in_x      = 8'd17;
      in_y      = 8'd9;
      tick();
      in_valid = 1'b0;
      while (if2.out_valid !== 1'b1 && cyc < 10) begin
         tick();
         cyc++;
      end
      checks++;
      if (if2.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL l0_timeout got %0d want 1", if2.out_valid); end
      checks++;
      if (if2.out_z !== 16'd153) begin errors++; $display("[TB] FAIL l0_exact got %0d want 153", if2.out_z); end
      checks++;
      if (if0.out_z !== want_main) begin errors++; $display("[TB] FAIL l0_main_approx got %0d want %0d", if0.out_z, want_main); end
      tick();
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      test_saturation();
      test_l0();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
